// File: rtl/bot_frame_timing.sv
// bot_frame_timing
// 640x480@60 raster generator plus the LocX/LocY/BotInfo registers the
// icon and world-map overlays read. New bot state is staged whenever it
// is requested. It is committed only on entry to vertical blanking, so the
// overlays never see a bot position change partway through a frame.
module bot_frame_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       upd_req,
    input  logic [7:0] LocX_in,
    input  logic [7:0] LocY_in,
    input  logic [7:0] BotInfo_in,
    output logic       upd_ack,
    output logic [7:0] LocX_reg,
    output logic [7:0] LocY_reg,
    output logic [7:0] BotInfo_reg,
    output logic [9:0] Pixel_row,
    output logic [9:0] Pixel_column,
    output logic       horiz_sync,
    output logic       vert_sync,
    output logic       video_on,
    output logic       frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] w_col_nxt;
    logic [9:0] w_row_nxt;
    logic       w_hs_nxt;
    logic       w_vs_nxt;
    logic       w_vid_nxt;
    logic       w_commit_pt;
    logic       w_commit;

    logic       r_pending;
    logic [7:0] r_stage_x;
    logic [7:0] r_stage_y;
    logic [7:0] r_stage_info;

    // The next raster point and its decoded syncs. Decoding the next point
    // lets every registered output line up with the registered counters.
    always_comb begin
        w_col_nxt = Pixel_column;
        w_row_nxt = Pixel_row;
        if (Pixel_column == H_LAST) begin
            w_col_nxt = 10'd0;
            if (Pixel_row == V_LAST) begin
                w_row_nxt = 10'd0;
            end else begin
                w_row_nxt = Pixel_row + 10'd1;
            end
        end else begin
            w_col_nxt = Pixel_column + 10'd1;
        end
        w_hs_nxt    = !((w_col_nxt >= HS_START) && (w_col_nxt < HS_END));
        w_vs_nxt    = !((w_row_nxt >= VS_START) && (w_row_nxt < VS_END));
        w_vid_nxt   = (w_col_nxt < H_VIS) && (w_row_nxt < V_VIS);
        w_commit_pt = (w_row_nxt == V_VIS) && (w_col_nxt == 10'd0);
        w_commit    = w_commit_pt && r_pending;
    end

    // Raster counters and their sync, blanking and frame-tick outputs.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            Pixel_column <= 10'd0;
            Pixel_row    <= 10'd0;
            horiz_sync   <= 1'b1;
            vert_sync    <= 1'b1;
            video_on     <= 1'b1;
            frame_tick   <= 1'b0;
        end else begin
            Pixel_column <= w_col_nxt;
            Pixel_row    <= w_row_nxt;
            horiz_sync   <= w_hs_nxt;
            vert_sync    <= w_vs_nxt;
            video_on     <= w_vid_nxt;
            frame_tick   <= w_commit_pt;
        end
    end

    // Stage requested bot state, then commit it to the overlay registers
    // only on entry to vertical blanking. A request on the commit edge is
    // captured into staging and waits for the next frame.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_stage_x    <= 8'h00;
            r_stage_y    <= 8'h00;
            r_stage_info <= 8'h00;
            LocX_reg     <= 8'h00;
            LocY_reg     <= 8'h00;
            BotInfo_reg  <= 8'h00;
            upd_ack      <= 1'b0;
        end else begin
            upd_ack <= w_commit;
            if (w_commit) begin
                LocX_reg    <= r_stage_x;
                LocY_reg    <= r_stage_y;
                BotInfo_reg <= r_stage_info;
            end
            if (upd_req) begin
                r_stage_x    <= LocX_in;
                r_stage_y    <= LocY_in;
                r_stage_info <= BotInfo_in;
                r_pending    <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bot_frame_timing.sv
// Testbench for bot_frame_timing. A default-size instance checks the real
// 640x480 line timing. A small-raster instance makes whole frames and bot
// commits affordable to simulate. Expectations come from a cycle-count
// model: point = f(cycles since reset), with commits at vertical blanking.
module tb_bot_frame_timing;

    // small raster: 25 x 19, commit point (12,0)
    localparam int SH_VIS = 16, SH_FP = 2, SH_SY = 4, SH_BP = 3;
    localparam int SV_VIS = 12, SV_FP = 2, SV_SY = 2, SV_BP = 3;
    localparam int SHT = SH_VIS + SH_FP + SH_SY + SH_BP;
    localparam int SVT = SV_VIS + SV_FP + SV_SY + SV_BP;
    localparam int SFT = SHT * SVT;
    // default raster
    localparam int DHT = 800, DVT = 525, DFT = DHT * DVT;

    logic       clk, rst, upd_req;
    logic [7:0] locx_in, locy_in, bot_in;

    logic       s_ack, s_hs, s_vs, s_vid, s_tick;
    logic [7:0] s_x, s_y, s_b;
    logic [9:0] s_row, s_col;
    logic       d_ack, d_hs, d_vs, d_vid, d_tick;
    logic [7:0] d_x, d_y, d_b;
    logic [9:0] d_row, d_col;

    logic [48:0] s_obs, d_obs;
    assign s_obs = {s_row, s_col, s_hs, s_vs, s_vid, s_tick, s_ack, s_x, s_y, s_b};
    assign d_obs = {d_row, d_col, d_hs, d_vs, d_vid, d_tick, d_ack, d_x, d_y, d_b};

    localparam logic [48:0] RESET_OBS = {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

    int checks = 0;
    int errors = 0;

    // model state
    int         k;
    bit         m_pend, m_ack, m_tick;
    logic [7:0] m_stx, m_sty, m_stb, m_x, m_y, m_b;

    bot_frame_timing #(
        .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SY), .H_BACK(SH_BP),
        .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SY), .V_BACK(SV_BP)
    ) u_small (
        .clock(clk), .rst(rst), .upd_req(upd_req),
        .LocX_in(locx_in), .LocY_in(locy_in), .BotInfo_in(bot_in),
        .upd_ack(s_ack), .LocX_reg(s_x), .LocY_reg(s_y), .BotInfo_reg(s_b),
        .Pixel_row(s_row), .Pixel_column(s_col),
        .horiz_sync(s_hs), .vert_sync(s_vs), .video_on(s_vid), .frame_tick(s_tick)
    );

    bot_frame_timing u_dflt (
        .clock(clk), .rst(rst), .upd_req(upd_req),
        .LocX_in(locx_in), .LocY_in(locy_in), .BotInfo_in(bot_in),
        .upd_ack(d_ack), .LocX_reg(d_x), .LocY_reg(d_y), .BotInfo_reg(d_b),
        .Pixel_row(d_row), .Pixel_column(d_col),
        .horiz_sync(d_hs), .vert_sync(d_vs), .video_on(d_vid), .frame_tick(d_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [48:0] exp_small();
        int  c = k % SHT;
        int  r = (k / SHT) % SVT;
        logic hs  = !((c >= SH_VIS + SH_FP) && (c < SH_VIS + SH_FP + SH_SY));
        logic vs  = !((r >= SV_VIS + SV_FP) && (r < SV_VIS + SV_FP + SV_SY));
        logic vid = (c < SH_VIS) && (r < SV_VIS);
        return {10'(r), 10'(c), hs, vs, vid, m_tick, m_ack, m_x, m_y, m_b};
    endfunction

    // default-size instance never reaches its commit point within this run
    function automatic logic [48:0] exp_dflt();
        int  c = k % DHT;
        int  r = (k / DHT) % DVT;
        logic hs  = !((c >= 656) && (c < 752));
        logic vs  = !((r >= 490) && (r < 492));
        logic vid = (c < 640) && (r < 480);
        logic tk  = ((k % DFT) == 480 * DHT);
        return {10'(r), 10'(c), hs, vs, vid, tk, 1'b0, 24'h000000};
    endfunction

    task automatic model_reset();
        k = 0; m_pend = 1'b0; m_ack = 1'b0; m_tick = 1'b0;
        m_stx = 8'h00; m_sty = 8'h00; m_stb = 8'h00;
        m_x = 8'h00; m_y = 8'h00; m_b = 8'h00;
    endtask

    // advance one clock and update the model; returns 1 time unit after the edge
    task automatic tick();
        int p;
        @(posedge clk);
        p = k + 1;
        m_tick = ((p % SFT) == SV_VIS * SHT);
        m_ack  = m_tick && m_pend;
        if (m_ack) begin
            m_x = m_stx; m_y = m_sty; m_b = m_stb;
        end
        if (upd_req) begin
            m_stx = locx_in; m_sty = locy_in; m_stb = bot_in; m_pend = 1'b1;
        end else if (m_ack) begin
            m_pend = 1'b0;
        end
        k = p;
        #1;
    endtask

    task automatic run_to(input int r, input int c);
        int n = 0;
        while (!(((k / SHT) % SVT) == r && (k % SHT) == c) && n < SFT + 1) begin
            tick();
            n++;
        end
    endtask

    task automatic set_req(input logic [7:0] x, input logic [7:0] y, input logic [7:0] b);
        upd_req = 1'b1; locx_in = x; locy_in = y; bot_in = b;
        tick();
        upd_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; upd_req = 1'b0; locx_in = 8'h00; locy_in = 8'h00; bot_in = 8'h00;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (s_obs !== RESET_OBS) begin errors++; $display("FAIL reset_small got %h exp %h", s_obs, RESET_OBS); end
        checks++;
        if (d_obs !== RESET_OBS) begin errors++; $display("FAIL reset_dflt got %h exp %h", d_obs, RESET_OBS); end
        rst = 1'b0;
        model_reset();
        tick();
        checks++;
        if (s_col !== 10'd1 || d_col !== 10'd1) begin
            errors++; $display("FAIL first_edge_col got %0d/%0d exp 1", s_col, d_col);
        end
    endtask

    task automatic test_line_default();
        int hs_low = 0, vid_hi = 0;
        for (int i = 0; i < 2 * DHT + 1; i++) begin
            checks++;
            if (d_obs !== exp_dflt()) begin
                errors++; $display("FAIL line_dflt k=%0d got %h exp %h", k, d_obs, exp_dflt());
            end
            if (k >= DHT && k < 2 * DHT) begin
                if (!d_hs) hs_low++;
                if (d_vid) vid_hi++;
            end
            tick();
        end
        checks++;
        if (hs_low != 96) begin errors++; $display("FAIL hsync_width got %0d exp 96", hs_low); end
        checks++;
        if (vid_hi != 640) begin errors++; $display("FAIL video_width got %0d exp 640", vid_hi); end
    endtask

    task automatic test_frame_small();
        int ticks = 0, vs_low = 0;
        run_to(0, 0);
        for (int i = 0; i < 2 * SFT; i++) begin
            tick();
            checks++;
            if (s_obs !== exp_small()) begin
                errors++; $display("FAIL frame_small k=%0d got %h exp %h", k, s_obs, exp_small());
            end
            if (s_tick) ticks++;
            if (!s_vs) vs_low++;
        end
        checks++;
        if (ticks != 2) begin errors++; $display("FAIL frame_tick_count got %0d exp 2", ticks); end
        checks++;
        if (vs_low != 2 * SV_SY * SHT) begin
            errors++; $display("FAIL vsync_width got %0d exp %0d", vs_low, 2 * SV_SY * SHT);
        end
    endtask

    task automatic test_single_update();
        run_to(3, 5);
        set_req(8'h12, 8'h34, 8'h03);
        while (!(((k / SHT) % SVT) == SV_VIS && (k % SHT) == 0)) begin
            checks++;
            if ({s_x, s_y, s_b, s_ack} !== {24'h000000, 1'b0}) begin
                errors++; $display("FAIL early_commit k=%0d got %h%h%h ack %b exp 000000 ack 0", k, s_x, s_y, s_b, s_ack);
            end
            tick();
        end
        checks++;
        if ({s_x, s_y, s_b, s_ack} !== {8'h12, 8'h34, 8'h03, 1'b1}) begin
            errors++; $display("FAIL single_commit got %h%h%h ack %b exp 123403 ack 1", s_x, s_y, s_b, s_ack);
        end
        tick();
        checks++;
        if (s_ack !== 1'b0 || s_obs !== exp_small()) begin
            errors++; $display("FAIL ack_one_cycle got %h exp %h", s_obs, exp_small());
        end
    endtask

    task automatic test_overwrite();
        int acks = 0;
        run_to(1, 0);
        set_req(8'h11, 8'h00, 8'h00);
        run_to(2, 0);
        set_req(8'h22, 8'h00, 8'h00);
        for (int i = 0; i < SFT; i++) begin
            checks++;
            if (s_obs !== exp_small()) begin
                errors++; $display("FAIL overwrite k=%0d got %h exp %h", k, s_obs, exp_small());
            end
            if (s_ack) acks++;
            tick();
        end
        checks++;
        if (acks != 1 || s_x !== 8'h22) begin
            errors++; $display("FAIL overwrite_result acks %0d x %h exp acks 1 x 22", acks, s_x);
        end
    endtask

    task automatic test_commit_cycle();
        run_to(2, 0);
        set_req(8'h05, 8'h00, 8'h00);
        run_to(SV_VIS - 1, SHT - 1);
        set_req(8'h06, 8'h00, 8'h00);
        checks++;
        if (s_x !== 8'h05 || s_ack !== 1'b1) begin
            errors++; $display("FAIL commit_cycle_old x %h ack %b exp 05 ack 1", s_x, s_ack);
        end
        tick();
        run_to(SV_VIS, 0);
        checks++;
        if (s_x !== 8'h06 || s_ack !== 1'b1 || s_obs !== exp_small()) begin
            errors++; $display("FAIL commit_cycle_new x %h ack %b exp 06 ack 1", s_x, s_ack);
        end
    endtask

    task automatic test_reset_midframe();
        int acks = 0;
        run_to(1, 0);
        set_req(8'h77, 8'h66, 8'h55);
        run_to(6, 10);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s_obs !== RESET_OBS) begin errors++; $display("FAIL midreset_small got %h exp %h", s_obs, RESET_OBS); end
        checks++;
        if (d_obs !== RESET_OBS) begin errors++; $display("FAIL midreset_dflt got %h exp %h", d_obs, RESET_OBS); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int i = 0; i < SFT + 2; i++) begin
            tick();
            checks++;
            if (s_obs !== exp_small()) begin
                errors++; $display("FAIL after_reset k=%0d got %h exp %h", k, s_obs, exp_small());
            end
            if (s_ack) acks++;
        end
        checks++;
        if (acks != 0 || s_x !== 8'h00) begin
            errors++; $display("FAIL discarded_stage acks %0d x %h exp acks 0 x 00", acks, s_x);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * SFT; i++) begin
            upd_req = ($urandom_range(0, 99) < 4);
            locx_in = 8'($urandom); locy_in = 8'($urandom); bot_in = 8'($urandom);
            tick();
            checks++;
            if (s_obs !== exp_small()) begin
                errors++; $display("FAIL random_small k=%0d got %h exp %h", k, s_obs, exp_small());
            end
            checks++;
            if (d_obs !== exp_dflt()) begin
                errors++; $display("FAIL random_dflt k=%0d got %h exp %h", k, d_obs, exp_dflt());
            end
        end
        upd_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_default();
        test_frame_small();
        test_single_update();
        test_overwrite();
        test_commit_cycle();
        test_reset_midframe();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
